// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcodes, FSM encodings, legal-op check.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_LUI: is_legal_op = 1'b1;
      default:                                    is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_grant2.sv
// Two-way grant: round-robin on ties, or fixed priority to port 0 when PRIO_MODE=1.
module rr_grant2 #(
  parameter int PRIO_MODE = 0
) (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant from the current requests and the previous winner
  always_comb begin
    grant = 2'b00;
    if (PRIO_MODE != 0) begin
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end else begin
      if (req_valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one external ALU and returns the result per port.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for a request; req_ready follows the grant
//  ST_EXEC | operands registered, ALU settling; capture on the next edge
//  ST_RESP | response held on the granted port until it is accepted
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [3:0]  req_op1,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [31:0] alu_read1,
  output logic [31:0] alu_read2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_iseq,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_res,
  output logic        resp_iseq,
  output logic        resp_err
);

  state_t     state;
  logic       last_grant;
  logic       gsel;
  logic [1:0] grant;

  rr_grant2 #(.PRIO_MODE(PRIO_MODE)) u_grant (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Accept only in IDLE so a single op is ever in flight
  always_comb begin
    req_ready = 2'b00;
    if (state == ST_IDLE) req_ready = grant;
  end

  // Sequencer plus operand and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gsel       <= 1'b0;
      alu_read1  <= '0;
      alu_read2  <= '0;
      alu_op     <= '0;
      resp_valid <= 2'b00;
      resp_res   <= '0;
      resp_iseq  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            if (grant[1]) begin
              alu_op    <= req_op1;
              alu_read1 <= req_a1;
              alu_read2 <= req_b1;
            end else begin
              alu_op    <= req_op0;
              alu_read1 <= req_a0;
              alu_read2 <= req_b0;
            end
            gsel       <= grant[1];
            last_grant <= grant[1];
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_res   <= alu_res;
          resp_iseq  <= alu_iseq;
          resp_err   <= ~is_legal_op(alu_op);
          resp_valid <= gsel ? 2'b10 : 2'b01;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the granted port's ready completes the response
          if (resp_ready[gsel]) begin
            resp_valid <= 2'b00;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
